sc_lanedriver_26: RTL and testbench
===================================

SC_LANEDRIVER_26 -- requirements
Module: sc_lanedriver_26

Interface
REQ-001 The block SHALL have parameter DATAWIDTH, default 12, width of the lane register it drives.
REQ-002 The block SHALL have parameter PERIOD_WIDTH, default 24, width of the shift prescaler.
REQ-003 The block SHALL have parameter SHIFT_PERIOD, default 24'd5000000, base clock cycles between shift strobes.
REQ-004 The block SHALL have parameter INIT_PATTERN, default 12'b000000000000, value presented on the load cycle.
REQ-005 The block SHALL have parameter LFSR_SEED, default 8'hA5, random generator start value.
REQ-006 The block SHALL have port SC_RegBACKGTYPE_CLOCK_50, input, 1 bit: clock.
REQ-007 The block SHALL have port SC_RegBACKGTYPE_RESET_InHigh, input, 1 bit: reset, asynchronous, active-high.
REQ-008 The block SHALL have port SC_LaneDriver_start_InLow, input, 1 bit: start/restart request, level, active-low.
REQ-009 The block SHALL have port SC_LaneDriver_pause_InHigh, input, 1 bit: freeze shifting.
REQ-010 The block SHALL have port SC_LaneDriver_speed_In, input, 2 bits: period divisor exponent.
REQ-011 The block SHALL have port SC_LaneDriver_clear_OutLow, output, 1 bit: lane clear strobe.
REQ-012 The block SHALL have port SC_LaneDriver_load_OutLow, output, 1 bit: lane load strobe.
REQ-013 The block SHALL have port SC_LaneDriver_shiftselection_Out, output, 2 bits: 2'b10 means shift, otherwise hold.
REQ-014 The block SHALL have port SC_LaneDriver_data_OutBUS, output, DATAWIDTH bits: load value.
REQ-015 The block SHALL have port SC_LaneDriver_random_OutBUS, output, 4 bits: refill nibble.
REQ-016 The block SHALL have port SC_LaneDriver_busy_Out, output, 1 bit: high during the CLEAR and LOAD states.
REQ-017 The block SHALL have port SC_LaneDriver_shiftcount_OutBUS, output, 8 bits: strobes issued since the last LOAD.

Function
REQ-018 The FSM SHALL have states IDLE, CLEAR, LOAD, RUN and PAUSE, with all outputs registered.
REQ-019 In IDLE, start_InLow=0 SHALL move the FSM to CLEAR on the next edge.
REQ-020 CLEAR SHALL last exactly 1 cycle with clear_OutLow=0 and then go to LOAD.
REQ-021 LOAD SHALL last exactly 1 cycle with load_OutLow=0 and data_OutBUS=INIT_PATTERN, then go to RUN with the prescaler=0 and shiftcount=0.
REQ-022 data_OutBUS SHALL equal INIT_PATTERN at all times.
REQ-023 Effective period P SHALL be SHIFT_PERIOD >> speed_In, with P forced to 1 when the shift gives 0.
REQ-024 In RUN the prescaler SHALL increment every cycle; when prescaler >= P-1 it SHALL wrap to 0 and shiftselection_Out SHALL be 2'b10 for exactly that one cycle; otherwise shiftselection_Out SHALL be 2'b00.
REQ-025 A speed_In change mid-count SHALL take effect immediately; a prescaler already >= the new P-1 SHALL wrap on the next cycle.
REQ-026 shiftcount SHALL increment on each strobe and wrap 255 -> 0.
REQ-027 The LFSR SHALL be 8-bit Fibonacci with taps x^8+x^6+x^5+x^4+1, shifting left with feedback into bit 0.
REQ-028 A LFSR_SEED of 0 SHALL be replaced by 8'h01.
REQ-029 random_OutBUS SHALL equal LFSR[3:0] and SHALL be stable during the strobe cycle; the LFSR SHALL advance on the cycle after each strobe only.
REQ-030 In RUN, pause_InHigh=1 SHALL move the FSM to PAUSE.
REQ-031 PAUSE SHALL hold the prescaler, LFSR and shiftcount, with no strobes.
REQ-032 pause_InHigh=0 in PAUSE SHALL return the FSM to RUN, resuming from the held prescaler value.
REQ-033 start_InLow=0 in RUN or PAUSE SHALL restart the sequence at CLEAR; restart SHALL win over a coincident strobe, which is suppressed, and over pause.
REQ-034 start_InLow held low SHALL NOT retrigger: a restart SHALL require start_InLow to return high after LOAD.
REQ-035 In CLEAR and LOAD, pause_InHigh SHALL be ignored.
REQ-036 clear_OutLow and load_OutLow SHALL never be low in the same cycle.
REQ-037 shiftselection_Out SHALL be 2'b00 whenever clear_OutLow or load_OutLow is low.

Reset
REQ-038 Asserting SC_RegBACKGTYPE_RESET_InHigh SHALL immediately force IDLE, clear_OutLow=1, load_OutLow=1, shiftselection_Out=2'b00, busy_Out=0, shiftcount=0, prescaler=0, LFSR=seed and random_OutBUS=seed[3:0].
REQ-039 Reset SHALL take priority over all inputs in any state, including mid-CLEAR or LOAD.
REQ-040 After reset release the FSM SHALL remain in IDLE until start_InLow=0.

Verification (SHIFT_PERIOD=8, LFSR_SEED=8'hA5, INIT_PATTERN=12'hF0F)
REQ-041 Reset, then start_InLow low 1 cycle -> clear_OutLow=0 for 1 cycle, then load_OutLow=0 with data 12'hF0F for 1 cycle, busy_Out=1 for both, then RUN.
REQ-042 RUN with speed_In=0 for 40 cycles -> strobes 2'b10 every 8th cycle, 1 cycle wide, shiftcount=5; random_OutBUS=4'h5 on the first strobe, and on each later strobe random_OutBUS equals LFSR[3:0] after one further LFSR step.
REQ-043 speed_In=2 (P=2) -> a strobe every 2nd cycle; speed_In switched 0->3 at prescaler=5 -> wrap on the next cycle.
REQ-044 pause_InHigh high for 20 cycles at prescaler=3 -> no strobes and values frozen; after release the first strobe comes 5 cycles later.
REQ-045 start_InLow low on a strobe cycle -> no 2'b10, CLEAR next, shiftcount=0 after LOAD; start_InLow held low -> a single CLEAR/LOAD pair.
REQ-046 Reset asserted during LOAD -> outputs at reset values in the same cycle and IDLE after release; a 256-strobe run -> shiftcount wraps to 0.

Source files
------------

// File: rtl/sc_lanedriver_26_if.sv
// Lane driver control/status bundle: requests in from the controller, lane strobes and status out.
interface sc_lanedriver_26_if #(
    parameter int unsigned DATAWIDTH = 12
);
    logic                 SC_LaneDriver_start_InLow;
    logic                 SC_LaneDriver_pause_InHigh;
    logic [1:0]           SC_LaneDriver_speed_In;
    logic                 SC_LaneDriver_clear_OutLow;
    logic                 SC_LaneDriver_load_OutLow;
    logic [1:0]           SC_LaneDriver_shiftselection_Out;
    logic [DATAWIDTH-1:0] SC_LaneDriver_data_OutBUS;
    logic [3:0]           SC_LaneDriver_random_OutBUS;
    logic                 SC_LaneDriver_busy_Out;
    logic [7:0]           SC_LaneDriver_shiftcount_OutBUS;

    modport master (
        output SC_LaneDriver_start_InLow, SC_LaneDriver_pause_InHigh, SC_LaneDriver_speed_In,
        input  SC_LaneDriver_clear_OutLow, SC_LaneDriver_load_OutLow,
               SC_LaneDriver_shiftselection_Out, SC_LaneDriver_data_OutBUS,
               SC_LaneDriver_random_OutBUS, SC_LaneDriver_busy_Out,
               SC_LaneDriver_shiftcount_OutBUS
    );

    modport slave (
        input  SC_LaneDriver_start_InLow, SC_LaneDriver_pause_InHigh, SC_LaneDriver_speed_In,
        output SC_LaneDriver_clear_OutLow, SC_LaneDriver_load_OutLow,
               SC_LaneDriver_shiftselection_Out, SC_LaneDriver_data_OutBUS,
               SC_LaneDriver_random_OutBUS, SC_LaneDriver_busy_Out,
               SC_LaneDriver_shiftcount_OutBUS
    );
endinterface

// File: rtl/sc_lanedriver_26.sv
// Lane driver: clear/load sequence, then periodic shift strobes with an LFSR refill nibble.
module sc_lanedriver_26 #(
    parameter int unsigned             DATAWIDTH    = 12,
    parameter int unsigned             PERIOD_WIDTH = 24,
    parameter logic [PERIOD_WIDTH-1:0] SHIFT_PERIOD = 24'd5000000,
    parameter logic [DATAWIDTH-1:0]    INIT_PATTERN = 12'b000000000000,
    parameter logic [7:0]              LFSR_SEED    = 8'hA5
) (
    input logic               SC_RegBACKGTYPE_CLOCK_50,
    input logic               SC_RegBACKGTYPE_RESET_InHigh,
    sc_lanedriver_26_if.slave lane
);
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_LOAD  = 3'd2,
        ST_RUN   = 3'd3,
        ST_PAUSE = 3'd4
    } state_t;

    localparam logic [7:0] SEED_EFF   = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    localparam logic [1:0] SEL_SHIFT  = 2'b10;
    localparam logic [1:0] SEL_HOLD   = 2'b00;

    state_t                  state_q, state_d;
    logic [PERIOD_WIDTH-1:0] presc_q, presc_d;
    logic [7:0]              count_q, count_d;
    logic [7:0]              lfsr_q, lfsr_d;
    logic                    armed_q, armed_d;
    logic                    clear_n_q, clear_n_d;
    logic                    load_n_q, load_n_d;
    logic                    busy_q, busy_d;
    logic [1:0]              shiftsel_q, shiftsel_d;

    logic [PERIOD_WIDTH-1:0] period_c;
    logic [PERIOD_WIDTH-1:0] limit_c;
    logic                    restart_c;
    logic                    count_en_c;

    // Effective period follows speed_In combinationally so a change applies on the current compare.
    always_comb begin
        period_c = SHIFT_PERIOD >> lane.SC_LaneDriver_speed_In;
        limit_c  = (period_c == '0) ? '0 : period_c - PERIOD_WIDTH'(1);
    end

    always_ff @(posedge SC_RegBACKGTYPE_CLOCK_50 or posedge SC_RegBACKGTYPE_RESET_InHigh) begin
        if (SC_RegBACKGTYPE_RESET_InHigh) begin
            state_q    <= ST_IDLE;
            presc_q    <= '0;
            count_q    <= '0;
            lfsr_q     <= SEED_EFF;
            armed_q    <= 1'b0;
            clear_n_q  <= 1'b1;
            load_n_q   <= 1'b1;
            busy_q     <= 1'b0;
            shiftsel_q <= SEL_HOLD;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            count_q    <= count_d;
            lfsr_q     <= lfsr_d;
            armed_q    <= armed_d;
            clear_n_q  <= clear_n_d;
            load_n_q   <= load_n_d;
            busy_q     <= busy_d;
            shiftsel_q <= shiftsel_d;
        end
    end

    // Restart needs start to have been seen high since the last LOAD, so a held-low start fires once.
    always_comb begin
        state_d   = state_q;
        restart_c = !lane.SC_LaneDriver_start_InLow && armed_q;
        unique case (state_q)
            ST_IDLE:  if (!lane.SC_LaneDriver_start_InLow) state_d = ST_CLEAR;
            ST_CLEAR: state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_RUN;
            ST_RUN: begin
                if (restart_c)                            state_d = ST_CLEAR;
                else if (lane.SC_LaneDriver_pause_InHigh) state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (restart_c)                             state_d = ST_CLEAR;
                else if (!lane.SC_LaneDriver_pause_InHigh) state_d = ST_RUN;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        presc_d    = presc_q;
        count_d    = count_q;
        lfsr_d     = lfsr_q;
        armed_d    = armed_q;
        shiftsel_d = SEL_HOLD;
        count_en_c = ((state_q == ST_RUN) || (state_q == ST_PAUSE)) && (state_d == ST_RUN);

        if (count_en_c) begin
            if (presc_q >= limit_c) begin
                presc_d    = '0;
                count_d    = count_q + 8'd1;
                shiftsel_d = SEL_SHIFT;
            end else begin
                presc_d = presc_q + PERIOD_WIDTH'(1);
            end
        end
        if ((state_d == ST_CLEAR) || (state_d == ST_LOAD)) begin
            presc_d = '0;
            count_d = '0;
        end

        // Refill nibble holds through the strobe cycle and advances right after it.
        if (shiftsel_q == SEL_SHIFT)
            lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

        if (state_d == ST_CLEAR)
            armed_d = 1'b0;
        else if (lane.SC_LaneDriver_start_InLow && ((state_q == ST_RUN) || (state_q == ST_PAUSE)))
            armed_d = 1'b1;

        clear_n_d = (state_d != ST_CLEAR);
        load_n_d  = (state_d != ST_LOAD);
        busy_d    = (state_d == ST_CLEAR) || (state_d == ST_LOAD);
    end

    assign lane.SC_LaneDriver_clear_OutLow       = clear_n_q;
    assign lane.SC_LaneDriver_load_OutLow        = load_n_q;
    assign lane.SC_LaneDriver_shiftselection_Out = shiftsel_q;
    assign lane.SC_LaneDriver_data_OutBUS        = INIT_PATTERN;
    assign lane.SC_LaneDriver_random_OutBUS      = lfsr_q[3:0];
    assign lane.SC_LaneDriver_busy_Out           = busy_q;
    assign lane.SC_LaneDriver_shiftcount_OutBUS  = count_q;
endmodule

// File: tb/tb_sc_lanedriver_26.sv
// Randomized and directed bench for sc_lanedriver_26 against a strobe/phase reference model.
module tb_sc_lanedriver_26;
    localparam int unsigned SP   = 8;
    localparam int unsigned NSEQ = 4096;

    localparam int M_IDLE  = 0;
    localparam int M_CLEAR = 1;
    localparam int M_LOAD  = 2;
    localparam int M_RUN   = 3;
    localparam int M_PAUSE = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sc_lanedriver_26_if #(.DATAWIDTH(12)) lane_if ();

    sc_lanedriver_26 #(
        .DATAWIDTH   (12),
        .PERIOD_WIDTH(24),
        .SHIFT_PERIOD(24'd8),
        .INIT_PATTERN(12'hF0F),
        .LFSR_SEED   (8'hA5)
    ) dut (
        .SC_RegBACKGTYPE_CLOCK_50    (clk),
        .SC_RegBACKGTYPE_RESET_InHigh(rst),
        .lane                        (lane_if.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int       m_phase;
    int       m_elapsed;
    int       m_count;
    int       m_strobes_done;
    bit       m_strobe;
    bit       m_armed;
    bit [7:0] lfsr_seq [NSEQ];

    function automatic bit [7:0] lfsr_next(input bit [7:0] v);
        bit [7:0] taps;
        taps = v & 8'hB8;
        return {v[6:0], ^taps};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase        = M_IDLE;
        m_elapsed      = 0;
        m_count        = 0;
        m_strobes_done = 0;
        m_strobe       = 1'b0;
        m_armed        = 1'b0;
    endtask

    task automatic model_edge();
        int  p;
        int  old_phase;
        bit  start_n;
        bit  pause;
        if (rst) begin
            model_reset();
            return;
        end
        start_n   = lane_if.SC_LaneDriver_start_InLow;
        pause     = lane_if.SC_LaneDriver_pause_InHigh;
        p         = SP >> lane_if.SC_LaneDriver_speed_In;
        if (p == 0) p = 1;
        old_phase = m_phase;
        if (m_strobe) m_strobes_done++;
        m_strobe = 1'b0;
        case (m_phase)
            M_IDLE:  if (!start_n) m_phase = M_CLEAR;
            M_CLEAR: m_phase = M_LOAD;
            M_LOAD:  m_phase = M_RUN;
            default: begin
                if (!start_n && m_armed) m_phase = M_CLEAR;
                else if (pause)          m_phase = M_PAUSE;
                else begin
                    m_phase = M_RUN;
                    m_elapsed++;
                    if (m_elapsed >= p) begin
                        m_elapsed = 0;
                        m_strobe  = 1'b1;
                        m_count   = (m_count + 1) % 256;
                    end
                end
            end
        endcase
        if (m_phase == M_CLEAR || m_phase == M_LOAD) begin
            m_elapsed = 0;
            m_count   = 0;
        end
        if (m_phase == M_CLEAR && old_phase != M_CLEAR)
            m_armed = 1'b0;
        else if (start_n && (old_phase == M_RUN || old_phase == M_PAUSE))
            m_armed = 1'b1;
    endtask

    task automatic check_all();
        bit [7:0] l;
        l = lfsr_seq[m_strobes_done % NSEQ];
        chk("clear_n",  32'(lane_if.SC_LaneDriver_clear_OutLow),       32'(m_phase != M_CLEAR));
        chk("load_n",   32'(lane_if.SC_LaneDriver_load_OutLow),        32'(m_phase != M_LOAD));
        chk("busy",     32'(lane_if.SC_LaneDriver_busy_Out),           32'(m_phase == M_CLEAR || m_phase == M_LOAD));
        chk("shiftsel", 32'(lane_if.SC_LaneDriver_shiftselection_Out), m_strobe ? 32'd2 : 32'd0);
        chk("count",    32'(lane_if.SC_LaneDriver_shiftcount_OutBUS),  32'(m_count));
        chk("random",   32'(lane_if.SC_LaneDriver_random_OutBUS),      32'(l[3:0]));
        chk("data",     32'(lane_if.SC_LaneDriver_data_OutBUS),        32'h0F0F);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        lfsr_seq[0] = 8'hA5;
        for (int i = 1; i < NSEQ; i++) lfsr_seq[i] = lfsr_next(lfsr_seq[i-1]);

        lane_if.SC_LaneDriver_start_InLow  = 1'b1;
        lane_if.SC_LaneDriver_pause_InHigh = 1'b0;
        lane_if.SC_LaneDriver_speed_In     = 2'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;
        step();
        step();

        // Start pulse: one CLEAR cycle, one LOAD cycle, then RUN
        lane_if.SC_LaneDriver_start_InLow = 1'b0;
        step();
        chk("clear_cycle", 32'(lane_if.SC_LaneDriver_clear_OutLow), 32'd0);
        lane_if.SC_LaneDriver_start_InLow = 1'b1;
        step();
        chk("load_cycle", 32'(lane_if.SC_LaneDriver_load_OutLow), 32'd0);
        chk("load_busy",  32'(lane_if.SC_LaneDriver_busy_Out),    32'd1);
        step();

        // Speed 0: strobe every 8th cycle, first refill nibble is seed[3:0]
        for (int i = 1; i <= 40; i++) begin
            step();
            chk("period8", 32'(lane_if.SC_LaneDriver_shiftselection_Out), (i % 8 == 0) ? 32'd2 : 32'd0);
            if (i == 8) chk("first_random", 32'(lane_if.SC_LaneDriver_random_OutBUS), 32'h5);
        end
        chk("count_after_40", 32'(lane_if.SC_LaneDriver_shiftcount_OutBUS), 32'd5);

        // Speed 2 gives period 2; then switch 0->3 at prescaler 5
        lane_if.SC_LaneDriver_speed_In = 2'd2;
        for (int i = 1; i <= 6; i++) begin
            step();
            chk("period2", 32'(lane_if.SC_LaneDriver_shiftselection_Out), (i % 2 == 0) ? 32'd2 : 32'd0);
        end
        lane_if.SC_LaneDriver_speed_In = 2'd0;
        repeat (5) step();
        lane_if.SC_LaneDriver_speed_In = 2'd3;
        step();
        chk("speed_jump_wrap", 32'(lane_if.SC_LaneDriver_shiftselection_Out), 32'd2);
        lane_if.SC_LaneDriver_speed_In = 2'd0;

        // Pause at prescaler 3 for 20 cycles; first strobe 5 cycles after release
        repeat (3) step();
        lane_if.SC_LaneDriver_pause_InHigh = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("paused_no_strobe", 32'(lane_if.SC_LaneDriver_shiftselection_Out), 32'd0);
        end
        lane_if.SC_LaneDriver_pause_InHigh = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("resume", 32'(lane_if.SC_LaneDriver_shiftselection_Out), (i == 5) ? 32'd2 : 32'd0);
        end

        // Restart on a strobe cycle, then held low: single CLEAR/LOAD pair
        repeat (7) step();
        lane_if.SC_LaneDriver_start_InLow = 1'b0;
        step();
        chk("restart_suppress", 32'(lane_if.SC_LaneDriver_shiftselection_Out), 32'd0);
        chk("restart_clear",    32'(lane_if.SC_LaneDriver_clear_OutLow),       32'd0);
        step();
        step();
        chk("count_after_load", 32'(lane_if.SC_LaneDriver_shiftcount_OutBUS), 32'd0);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("held_no_retrigger", 32'(lane_if.SC_LaneDriver_clear_OutLow), 32'd1);
        end
        lane_if.SC_LaneDriver_start_InLow = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 700; i++) begin
            lane_if.SC_LaneDriver_start_InLow = ($urandom_range(0, 29) != 0);
            if ($urandom_range(0, 19) == 0)
                lane_if.SC_LaneDriver_pause_InHigh = ~lane_if.SC_LaneDriver_pause_InHigh;
            if ($urandom_range(0, 24) == 0)
                lane_if.SC_LaneDriver_speed_In = 2'($urandom_range(0, 3));
            step();
        end
        lane_if.SC_LaneDriver_start_InLow  = 1'b1;
        lane_if.SC_LaneDriver_pause_InHigh = 1'b0;

        // 256 strobes at period 1 wrap the counter to 0
        lane_if.SC_LaneDriver_start_InLow = 1'b0;
        step();
        lane_if.SC_LaneDriver_start_InLow = 1'b1;
        step();
        step();
        lane_if.SC_LaneDriver_speed_In = 2'd3;
        for (int i = 1; i <= 256; i++) begin
            step();
            if (i == 255) chk("count_255", 32'(lane_if.SC_LaneDriver_shiftcount_OutBUS), 32'd255);
        end
        chk("count_wrap", 32'(lane_if.SC_LaneDriver_shiftcount_OutBUS), 32'd0);
        lane_if.SC_LaneDriver_speed_In = 2'd0;

        // Reset asserted during LOAD acts immediately
        step();
        lane_if.SC_LaneDriver_start_InLow = 1'b0;
        step();
        lane_if.SC_LaneDriver_start_InLow = 1'b1;
        step();
        chk("in_load", 32'(lane_if.SC_LaneDriver_load_OutLow), 32'd0);
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("rst_load_n", 32'(lane_if.SC_LaneDriver_load_OutLow), 32'd1);
        chk("rst_busy",   32'(lane_if.SC_LaneDriver_busy_Out),    32'd0);
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle_after_rst", 32'(lane_if.SC_LaneDriver_busy_Out), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
